// File: rtl/reg_writeback_pkg.sv
// Shared writeback definitions: default widths, the result record exchanged
// between the ALU, the load unit and the writeback stage, and arbiter selections.
package reg_writeback_pkg;

  localparam int unsigned DATA_W_DFLT = 32;
  localparam int unsigned ADDR_W_DFLT = 4;

  typedef struct packed {
    logic [ADDR_W_DFLT-1:0] addr;
    logic [DATA_W_DFLT-1:0] data;
  } wb_result_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_ALU_FORCED,
    SEL_LOAD,
    SEL_ALU
  } wb_sel_e;

endpackage

// File: rtl/reg_writeback_if.sv
// Result handshakes, issue notification, scoreboard and register-set write port.
interface reg_writeback_if
  import reg_writeback_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DFLT,
  parameter int unsigned ADDR_W = ADDR_W_DFLT
);
  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_addr;
  logic [NUM_REGS-1:0] pending;
  logic              writeEnable;
  logic [ADDR_W-1:0] writeAddress;
  logic [DATA_W-1:0] writeData;

  modport master (
    output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
           issue_valid, issue_addr,
    input  alu_ready, ld_ready, pending, writeEnable, writeAddress, writeData
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
           issue_valid, issue_addr,
    output alu_ready, ld_ready, pending, writeEnable, writeAddress, writeData
  );

endinterface

// File: rtl/reg_writeback_wb_fifo.sv
// Synchronous FIFO without fall-through; full/empty decode from the registered count.
module wb_fifo #(
  parameter  int unsigned WIDTH = 36,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW:0]      r_wr_ptr;
  logic [PW:0]      r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[PW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage: merges buffered ALU results and priority loads onto the single
// register-set write port, and tracks in-flight destinations in a pending scoreboard.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int unsigned DATA_W         = DATA_W_DFLT,
  parameter int unsigned ADDR_W         = ADDR_W_DFLT,
  parameter int unsigned ALU_FIFO_DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  reg_writeback_if.slave wb
);

  localparam int unsigned NUM_REGS = 1 << ADDR_W;
  localparam int unsigned FW       = ADDR_W + DATA_W;
  localparam int unsigned CW       = $clog2(ALU_FIFO_DEPTH) + 1;

  logic [FW-1:0]       w_alu_head;
  logic                w_full;
  logic                w_empty;
  logic [CW-1:0]       w_count;
  logic                w_push;
  logic                w_pop;
  wb_sel_e             w_sel;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clr;

  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic [NUM_REGS-1:0] r_pending;

  wb_fifo #(
    .WIDTH (FW),
    .DEPTH (ALU_FIFO_DEPTH)
  ) u_alu_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_wdata ({wb.alu_addr, wb.alu_data}),
    .i_pop   (w_pop),
    .o_rdata (w_alu_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Both readies depend only on the registered FIFO count, never on the valids.
  assign wb.alu_ready = !w_full;
  assign wb.ld_ready  = !w_full;
  assign w_push       = wb.alu_valid && !w_full;

  always_comb begin
    w_sel = SEL_NONE;
    if (w_full && !w_empty)  w_sel = SEL_ALU_FORCED;
    else if (wb.ld_valid)    w_sel = SEL_LOAD;
    else if (w_count != '0)  w_sel = SEL_ALU;
  end

  assign w_pop = (w_sel == SEL_ALU_FORCED) || (w_sel == SEL_ALU);
  assign w_set = wb.issue_valid ? (NUM_REGS'(1) << wb.issue_addr) : '0;
  assign w_clr = r_we ? (NUM_REGS'(1) << r_addr) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_pending <= '0;
    end else begin
      case (w_sel)
        SEL_LOAD: begin
          r_we   <= 1'b1;
          r_addr <= wb.ld_addr;
          r_data <= wb.ld_data;
        end
        SEL_ALU, SEL_ALU_FORCED: begin
          r_we   <= 1'b1;
          r_addr <= w_alu_head[FW-1:DATA_W];
          r_data <= w_alu_head[DATA_W-1:0];
        end
        default: r_we <= 1'b0;
      endcase
      // Set after clear: a new producer issued on the commit edge keeps its bit.
      r_pending <= (r_pending & ~w_clr) | w_set;
    end
  end

  assign wb.writeEnable  = r_we;
  assign wb.writeAddress = r_addr;
  assign wb.writeData    = r_data;
  assign wb.pending      = r_pending;

endmodule
